// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter: FSM states and grant IDs.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; the requester that did not win last time wins a tie.
import mem_arbiter_pkg::*;

module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic valid,
  output logic gnt
);

  always_comb begin
    valid = req_a | req_b;
    if (req_a && req_b) gnt = ~last;
    else if (req_b)     gnt = REQ_B;
    else                gnt = REQ_A;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port memory between fetch (A) and load/store (B).
// Optional write protection below WP_LIMIT is enabled by defining MEM_WP_EN.
//
// state      | meaning
// ARB_IDLE   | no access in flight, waiting for a request
// ARB_ACCESS | memory driven for the granted requester
// ARB_RESP   | ack pulse to the granted requester, requests ignored
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] WP_LIMIT = 10'd64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out,
  output logic              busy,
  output logic              wp_viol
);

  arb_state_t        state, next_state;
  logic              gnt_q, last_q;
  logic              pick_valid, pick_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              wp_hit;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  rr_pick2 u_pick (
    .req_a (a_req),
    .req_b (b_req),
    .last  (last_q),
    .valid (pick_valid),
    .gnt   (pick_gnt)
  );

  assign sel_we    = (gnt_q == REQ_B) ? b_we    : a_we;
  assign sel_addr  = (gnt_q == REQ_B) ? b_addr  : a_addr;
  assign sel_wdata = (gnt_q == REQ_B) ? b_wdata : a_wdata;

`ifdef MEM_WP_EN
  assign wp_hit = sel_we && (sel_addr < WP_LIMIT);
`else
  assign wp_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE:   if (pick_valid) next_state = ARB_ACCESS;
      ARB_ACCESS: next_state = ARB_RESP;
      ARB_RESP:   next_state = ARB_IDLE;
      default:    next_state = ARB_IDLE;
    endcase
  end

  // mem_w_en derives from state alone, so async reset drops it in the same instant
  always_comb begin
    mem_addr = '0;
    mem_d_in = '0;
    mem_w_en = 1'b0;
    a_ack    = 1'b0;
    b_ack    = 1'b0;
    busy     = (state != ARB_IDLE);
    case (state)
      ARB_ACCESS: begin
        mem_addr = sel_addr;
        mem_d_in = sel_wdata;
        mem_w_en = sel_we & ~wp_hit;
      end
      ARB_RESP: begin
        a_ack = (gnt_q == REQ_A);
        b_ack = (gnt_q == REQ_B);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= REQ_A;
      last_q    <= REQ_B;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (state == ARB_IDLE && pick_valid) gnt_q <= pick_gnt;
      if (state == ARB_ACCESS) begin
        last_q <= gnt_q;
        if (!sel_we) begin
          if (gnt_q == REQ_A) a_rdata_q <= mem_d_out;
          else                b_rdata_q <= mem_d_out;
        end
      end
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

`ifdef MEM_WP_EN
  logic err_q, wp_viol_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      wp_viol_q <= 1'b0;
    end else if (state == ARB_ACCESS) begin
      err_q <= wp_hit;
      if (wp_hit) wp_viol_q <= 1'b1;
    end
  end

  assign a_err   = a_ack & err_q;
  assign b_err   = b_ack & err_q;
  assign wp_viol = wp_viol_q;
`else
  // Protection compiled out; keep the limit referenced so the parameter stays part of the interface.
  logic unused_wp;
  assign unused_wp = ^WP_LIMIT;
  assign a_err     = 1'b0;
  assign b_err     = 1'b0;
  assign wp_viol   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1024x16 combinational-read memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [9:0]  mem_addr;
  logic        mem_w_en;
  logic [15:0] mem_d_in, mem_d_out;
  logic        busy, wp_viol;

  logic [15:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [15:0] pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_d_in(mem_d_in),
    .mem_d_out(mem_d_out), .busy(busy), .wp_viol(wp_viol)
  );

  assign mem_d_out = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_w_en)    mem[mem_addr] <= mem_d_in;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic preload(input logic [9:0] addr, input logic [15:0] data);
    pre_we = 1; pre_addr = addr; pre_data = data;
    tick();
    pre_we = 0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    pre_we = 0; pre_addr = '0; pre_data = '0;
    rst = 1;
    tick();
    for (int i = 0; i < 1024; i++) preload(10'(i), 16'h0000);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({a_ack, b_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {a_ack, b_ack}); end
    checks++; if ({a_err, b_err, wp_viol} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", {a_err, b_err, wp_viol}); end
    checks++; if ({a_rdata, b_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {a_rdata, b_rdata}); end
    checks++; if ({mem_w_en, mem_addr, mem_d_in} !== 27'h0) begin errors++; $display("FAIL reset_mem: got %h expected 0", {mem_w_en, mem_addr, mem_d_in}); end
    rst = 0;
  endtask

  task automatic test_read;
    apply_reset();
    preload(10'd5, 16'h1234);
    a_req = 1; a_we = 0; a_addr = 10'd5;
    tick();
    checks++; if ({busy, a_ack, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin errors++; $display("FAIL read_access: got busy/ack/addr %b/%b/%0d expected 1/0/5", busy, a_ack, mem_addr); end
    tick();
    checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL read_ack: got %b expected 1", a_ack); end
    checks++; if (a_rdata !== 16'h1234) begin errors++; $display("FAIL read_data: got %h expected 1234", a_rdata); end
    checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL read_b_ack: got %b expected 0", b_ack); end
    a_req = 0;
    tick();
    checks++; if ({a_ack, busy} !== 2'b00) begin errors++; $display("FAIL read_done: got ack/busy %b expected 00", {a_ack, busy}); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp;
    apply_reset();
    a_req = 1; a_we = 1; a_addr = 10'd100; a_wdata = 16'hAAAA;
    b_req = 1; b_we = 1; b_addr = 10'd200; b_wdata = 16'hBBBB;
    for (int k = 1; k <= 12; k++) begin
      tick();
      case (k)
        2, 8:    exp = 2'b10;
        5, 11:   exp = 2'b01;
        default: exp = 2'b00;
      endcase
      checks++; if ({a_ack, b_ack} !== exp) begin errors++; $display("FAIL rr_ack_cycle%0d: got ab=%b expected %b", k, {a_ack, b_ack}, exp); end
    end
    a_req = 0; b_req = 0;
    tick(); tick(); tick();
    checks++; if (mem[100] !== 16'hAAAA) begin errors++; $display("FAIL rr_mem100: got %h expected aaaa", mem[100]); end
    checks++; if (mem[200] !== 16'hBBBB) begin errors++; $display("FAIL rr_mem200: got %h expected bbbb", mem[200]); end
    checks++; if ({a_rdata, b_rdata} !== 32'h0) begin errors++; $display("FAIL rr_rdata_hold: got %h expected 0", {a_rdata, b_rdata}); end
  endtask

  task automatic test_req_drop;
    apply_reset();
    b_req = 1; b_we = 1; b_addr = 10'd300; b_wdata = 16'hBEEF;
    tick();
    b_req = 0;
    tick();
    checks++; if ({a_ack, b_ack} !== 2'b01) begin errors++; $display("FAIL drop_ack: got ab=%b expected 01", {a_ack, b_ack}); end
    checks++; if (mem[300] !== 16'hBEEF) begin errors++; $display("FAIL drop_mem300: got %h expected beef", mem[300]); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_access;
    apply_reset();
    preload(10'd7, 16'h5555);
    a_req = 1; a_we = 1; a_addr = 10'd7; a_wdata = 16'h7777;
    tick();
    checks++; if (mem_w_en !== 1'b1) begin errors++; $display("FAIL rstmid_wen_before: got %b expected 1", mem_w_en); end
    #2 rst = 1;
    #1;
    checks++; if (mem_w_en !== 1'b0) begin errors++; $display("FAIL rstmid_wen: got %b expected 0", mem_w_en); end
    checks++; if ({busy, a_ack, b_ack} !== 3'b000) begin errors++; $display("FAIL rstmid_busy_ack: got %b expected 000", {busy, a_ack, b_ack}); end
    tick();
    checks++; if (mem[7] !== 16'h5555) begin errors++; $display("FAIL rstmid_mem7: got %h expected 5555", mem[7]); end
    rst = 0;
    a_req = 1; a_we = 0; a_addr = 10'd7;
    b_req = 1; b_we = 0; b_addr = 10'd7;
    tick(); tick();
    checks++; if ({a_ack, b_ack} !== 2'b10) begin errors++; $display("FAIL rstmid_first_gnt: got ab=%b expected 10", {a_ack, b_ack}); end
    checks++; if (a_rdata !== 16'h5555) begin errors++; $display("FAIL rstmid_rdata: got %h expected 5555", a_rdata); end
    clear_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_write_protect;
    logic        exp_err;
    logic [15:0] exp_mem;
`ifdef MEM_WP_EN
    exp_err = 1'b1; exp_mem = 16'h0000;
`else
    exp_err = 1'b0; exp_mem = 16'h0F0F;
`endif
    apply_reset();
    preload(10'd10, 16'h0000);
    a_req = 1; a_we = 1; a_addr = 10'd10; a_wdata = 16'h0F0F;
    tick(); tick();
    checks++; if ({a_ack, a_err} !== {1'b1, exp_err}) begin errors++; $display("FAIL wp_ack_err: got %b expected %b", {a_ack, a_err}, {1'b1, exp_err}); end
    checks++; if (mem[10] !== exp_mem) begin errors++; $display("FAIL wp_mem10: got %h expected %h", mem[10], exp_mem); end
    a_req = 0;
    tick();
    checks++; if ({a_err, wp_viol} !== {1'b0, exp_err}) begin errors++; $display("FAIL wp_sticky: got err/viol %b expected %b", {a_err, wp_viol}, {1'b0, exp_err}); end
    a_req = 1; a_we = 1; a_addr = 10'd64; a_wdata = 16'h1111;
    tick(); tick();
    checks++; if ({a_ack, a_err} !== 2'b10) begin errors++; $display("FAIL wp_64_ack_err: got %b expected 10", {a_ack, a_err}); end
    checks++; if (mem[64] !== 16'h1111) begin errors++; $display("FAIL wp_mem64: got %h expected 1111", mem[64]); end
    a_req = 0;
    tick();
    checks++; if (wp_viol !== exp_err) begin errors++; $display("FAIL wp_viol_hold: got %b expected %b", wp_viol, exp_err); end
    apply_reset();
    checks++; if (wp_viol !== 1'b0) begin errors++; $display("FAIL wp_viol_rst: got %b expected 0", wp_viol); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_req_drop();
    test_reset_mid_access();
    test_write_protect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
